// File: rtl/yolo_detect_decoder.sv
// yolo_detect_decoder: streaming decode stage between the last conv layer and NMS.
// Takes raw predictions one word per cycle (x, y, w, h, obj, cls0..clsC-1 per box),
// applies a piecewise-linear sigmoid to x, y and obj, and passes w and h through.
// Boxes whose sigmoid(obj) is below obj_thresh are dropped without an input bubble.
// Surviving boxes are presented on a valid/ready output.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   raw word handshake; in_data is signed Q(DATA_W-FRAC_BITS).FRAC_BITS
//   obj_thresh          unsigned threshold, sampled with word 0 of each box
//   out_valid/out_ready decoded box handshake
//   out_x/y/w/h/obj     decoded fields; out_box_idx is the box index within the cell
//   cell_done           one-cycle pulse after the last box of a cell resolves
//   boxes_kept          boxes emitted for that cell, held until the next cell_done
//
// Optional build macro YOLO_DETECT_CLASS_ARGMAX_EN adds out_class/out_class_score
// (argmax over the class words, lowest index wins ties, score = sigmoid(max)).
module yolo_detect_decoder #(
  parameter int unsigned B         = 3,
  parameter int unsigned C         = 20,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_data,
  input  logic [DATA_W-1:0]                  obj_thresh,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_x,
  output logic [DATA_W-1:0]                  out_y,
  output logic [DATA_W-1:0]                  out_w,
  output logic [DATA_W-1:0]                  out_h,
  output logic [DATA_W-1:0]                  out_obj,
  output logic [((B > 1) ? $clog2(B) : 1)-1:0] out_box_idx,
`ifdef YOLO_DETECT_CLASS_ARGMAX_EN
  output logic [((C > 1) ? $clog2(C) : 1)-1:0] out_class,
  output logic [DATA_W-1:0]                  out_class_score,
`endif
  output logic                               cell_done,
  output logic [$clog2(B+1)-1:0]             boxes_kept
);

  localparam int unsigned BoxW     = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned KeptW    = $clog2(B + 1);
  localparam int unsigned Words    = 5 + C;
  localparam int unsigned CntW     = $clog2(Words);
  localparam int unsigned LastWord = Words - 1;
  localparam int unsigned OneI     = 32'd1 << FRAC_BITS;

  localparam logic [DATA_W-1:0] One     = DATA_W'(OneI);
  localparam logic [DATA_W-1:0] Half    = DATA_W'(OneI >> 1);
  localparam logic [DATA_W-1:0] Five    = DATA_W'(5 * OneI);
  localparam logic [DATA_W-1:0] T2375   = DATA_W'((19 * OneI) >> 3);
  localparam logic [DATA_W-1:0] K84375  = DATA_W'((27 * OneI) >> 5);
  localparam logic [DATA_W-1:0] K625    = DATA_W'((5 * OneI) >> 3);
  localparam logic [DATA_W-1:0] MostNeg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MaxPos  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [0:0] {StCollect, StEmit} state_e;

  function automatic logic [DATA_W-1:0] sigmoid(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] s;
    // |v| with the most-negative code saturated so it cannot wrap back negative
    if (v == MostNeg)       a = MaxPos;
    else if (v[DATA_W-1])   a = ~v + DATA_W'(1);
    else                    a = v;
    if (a >= Five)          s = One;
    else if (a >= T2375)    s = (a >> 5) + K84375;
    else if (a >= One)      s = (a >> 3) + K625;
    else                    s = (a >> 2) + Half;
    if (v[DATA_W-1])        s = One - s;
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   word_cnt_q;
  logic [BoxW-1:0]   box_cnt_q;
  logic [KeptW-1:0]  kept_cnt_q, boxes_kept_q;
  logic [DATA_W-1:0] thresh_q;
  logic [DATA_W-1:0] x_q, y_q, w_q, h_q, obj_q;
  logic              cell_done_q;

  logic              accept, last_word, keep, emit_hs, resolve, cell_end;
  logic [DATA_W-1:0] sig_in, obj_sig;

  always_comb begin
    accept    = in_valid & in_ready;
    sig_in    = sigmoid(in_data);
    last_word = accept && (word_cnt_q == CntW'(LastWord));
    // With no class words the obj word is the last word, so use it directly
    obj_sig   = (C == 0) ? sig_in : obj_q;
    keep      = obj_sig >= thresh_q;
    emit_hs   = (state_q == StEmit) & out_ready;
    resolve   = (last_word & ~keep) | emit_hs;
    cell_end  = resolve & (box_cnt_q == BoxW'(B - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (last_word && keep) state_d = StEmit;
      StEmit:    if (out_ready) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StCollect;
      word_cnt_q   <= '0;
      box_cnt_q    <= '0;
      kept_cnt_q   <= '0;
      boxes_kept_q <= '0;
      thresh_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      obj_q        <= '0;
      cell_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_cnt_q <= last_word ? '0 : word_cnt_q + CntW'(1);
        if (word_cnt_q == CntW'(0)) begin
          x_q      <= sig_in;
          thresh_q <= obj_thresh;
        end
        if (word_cnt_q == CntW'(1)) y_q   <= sig_in;
        if (word_cnt_q == CntW'(2)) w_q   <= in_data;
        if (word_cnt_q == CntW'(3)) h_q   <= in_data;
        if (word_cnt_q == CntW'(4)) obj_q <= sig_in;
      end
      if (resolve) box_cnt_q <= cell_end ? '0 : box_cnt_q + BoxW'(1);
      cell_done_q <= cell_end;
      if (cell_end) begin
        boxes_kept_q <= kept_cnt_q + KeptW'(emit_hs);
        kept_cnt_q   <= '0;
      end else if (emit_hs) begin
        kept_cnt_q <= kept_cnt_q + KeptW'(1);
      end
    end
  end

  // in_ready drops combinationally with rst so nothing is accepted during reset
  assign in_ready    = (state_q == StCollect) & ~rst;
  assign out_valid   = (state_q == StEmit);
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_w       = w_q;
  assign out_h       = h_q;
  assign out_obj     = obj_q;
  assign out_box_idx = box_cnt_q;
  assign cell_done   = cell_done_q;
  assign boxes_kept  = boxes_kept_q;

`ifdef YOLO_DETECT_CLASS_ARGMAX_EN
  localparam int unsigned ClsW = (C > 1) ? $clog2(C) : 1;

  logic signed [DATA_W-1:0] max_q, run_max;
  logic [ClsW-1:0]          max_idx_q, run_idx, class_q;
  logic [DATA_W-1:0]        class_score_q;
  logic                     is_cls;

  always_comb begin
    is_cls  = word_cnt_q >= CntW'(5);
    run_max = max_q;
    run_idx = max_idx_q;
    // Strict > keeps the earlier index on ties
    if ((word_cnt_q == CntW'(5)) || ($signed(in_data) > max_q)) begin
      run_max = $signed(in_data);
      run_idx = ClsW'(word_cnt_q - CntW'(5));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q         <= '0;
      max_idx_q     <= '0;
      class_q       <= '0;
      class_score_q <= '0;
    end else begin
      if (accept && is_cls) begin
        max_q     <= run_max;
        max_idx_q <= run_idx;
      end
      if (last_word) begin
        class_q       <= (C == 0) ? '0 : run_idx;
        class_score_q <= (C == 0) ? '0 : sigmoid(run_max);
      end
    end
  end

  assign out_class       = class_q;
  assign out_class_score = class_score_q;
`endif

endmodule

// File: tb/tb_yolo_detect_decoder.sv
module tb_yolo_detect_decoder;

  localparam int unsigned B = 3;
  localparam int unsigned C = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] obj_thresh;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x, out_y, out_w, out_h, out_obj;
  logic [1:0]  out_box_idx;
  logic        cell_done;
  logic [1:0]  boxes_kept;
`ifdef YOLO_DETECT_CLASS_ARGMAX_EN
  logic [4:0]  out_class;
  logic [15:0] out_class_score;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] cls_words [C];

  always #5 clk = ~clk;

  yolo_detect_decoder #(.B(B), .C(C), .DATA_W(16), .FRAC_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .obj_thresh      (obj_thresh),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_x           (out_x),
    .out_y           (out_y),
    .out_w           (out_w),
    .out_h           (out_h),
    .out_obj         (out_obj),
    .out_box_idx     (out_box_idx),
`ifdef YOLO_DETECT_CLASS_ARGMAX_EN
    .out_class       (out_class),
    .out_class_score (out_class_score),
`endif
    .cell_done       (cell_done),
    .boxes_kept      (boxes_kept)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic put(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_box(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                          input logic [15:0] h, input logic [15:0] obj);
    put(x); put(y); put(w); put(h); put(obj);
    for (int i = 0; i < C; i++) put(cls_words[i]);
  endtask

  task automatic take_box();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    obj_thresh = 16'd128;
    out_ready  = 1'b0;
    for (int i = 0; i < C; i++) cls_words[i] = '0;

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_cell_done", cell_done, 0);
    check("rst_boxes_kept", boxes_kept, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Cell A, box 0: basic decode, one cycle of latency
    send_box(16'h0000, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("b0_out_valid", out_valid, 1);
    check("b0_in_ready", in_ready, 0);
    check("b0_x", out_x, 128);
    check("b0_y", out_y, 192);
    check("b0_w", out_w, 16'h0123);
    check("b0_h", out_h, 16'h0045);
    check("b0_obj", out_obj, 256);
    check("b0_idx", out_box_idx, 0);
    take_box();
    check("b0_after_valid", out_valid, 0);
    check("b0_after_ready", in_ready, 1);

    // Sigmoid sweep
    send_box(16'hFF00, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("sw_neg1_x", out_x, 64);
    check("sw_neg1_idx", out_box_idx, 1);
    take_box();
    send_box(16'h0260, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("sw_2375_x", out_x, 235);
    check("sw_2375_idx", out_box_idx, 2);
    take_box();
    check("cellA_done", cell_done, 1);
    check("cellA_kept", boxes_kept, 3);
    @(posedge clk);
    #1;
    check("cellA_done_pulse", cell_done, 0);
    send_box(16'h8000, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("sw_mostneg_x", out_x, 0);
    check("sw_mostneg_idx", out_box_idx, 0);
    take_box();
    send_box(16'h7FFF, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("sw_maxpos_x", out_x, 256);
    take_box();
    send_box(16'h0000, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    take_box();

    // Cell C: box 1 suppressed, no bubble before box 2
    send_box(16'h0000, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    take_box();
    send_box(16'h0000, 16'h0100, 16'h0123, 16'h0045, 16'hFB00);
    check("sup_out_valid", out_valid, 0);
    check("sup_in_ready", in_ready, 1);
    send_box(16'h0100, 16'h0000, 16'h0011, 16'h0022, 16'h0500);
    check("sup_b2_valid", out_valid, 1);
    check("sup_b2_x", out_x, 192);
    check("sup_b2_w", out_w, 16'h0011);
    check("sup_b2_idx", out_box_idx, 2);
    take_box();
    check("cellC_done", cell_done, 1);
    check("cellC_kept", boxes_kept, 2);

    // Cell D, box 0: downstream stall for 10 cycles
    send_box(16'h0260, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold", {out_valid, in_ready, out_x, out_w}, {1'b1, 1'b0, 16'd235, 16'h0123});
    end
    take_box();
    check("stall_rel_valid", out_valid, 0);
    check("stall_rel_ready", in_ready, 1);

    // Reset after word 3 of a box
    put(16'h0100); put(16'h0100); put(16'h0123); put(16'h0045);
    rst = 1'b1;
    #1;
    check("mid_rst_x", out_x, 0);
    check("mid_rst_w", out_w, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    send_box(16'hFF00, 16'h0000, 16'h0077, 16'h0088, 16'h0500);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_x", out_x, 64);
    check("post_rst_y", out_y, 128);
    check("post_rst_h", out_h, 16'h0088);
    check("post_rst_idx", out_box_idx, 0);
    take_box();

`ifdef YOLO_DETECT_CLASS_ARGMAX_EN
    cls_words[0] = 16'd5;
    cls_words[1] = 16'd9;
    cls_words[2] = 16'd9;
    cls_words[3] = 16'hFFFD;
    send_box(16'h0000, 16'h0100, 16'h0123, 16'h0045, 16'h0500);
    check("argmax_class", out_class, 1);
    check("argmax_score", out_class_score, 130);
    take_box();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yolo_detect_decoder.md
Name: yolo_detect_decoder

Overview:
- Streaming successor to the detection-layer decode stage: accepts raw predictions one word per cycle over a valid/ready stream instead of a parallel array.
- Applies a real piecewise-linear sigmoid to x, y and objectness, and passes w and h through unchanged.
- Drops boxes whose objectness is below a runtime threshold and emits the surviving boxes over a valid/ready output.
- Sits between the last convolutional layer and NMS; processes one grid cell (B boxes) at a time.

Parameters:
- B, 3, boxes per grid cell (>=1)
- C, 20, class scores per box (>=0); words per box = 5+C
- DATA_W, 16, signed fixed-point word width
- FRAC_BITS, 8, fractional bits; 1.0 = 1<<FRAC_BITS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  raw word valid
- in_ready  out  1  decoder can accept a word
- in_data  in  DATA_W  raw word, signed Q(DATA_W-FRAC_BITS).FRAC_BITS; order per box: x,y,w,h,obj,cls0..clsC-1
- obj_thresh  in  DATA_W  objectness threshold (unsigned, same Q format), sampled when word 0 of each box is accepted
- out_valid  out  1  decoded box valid
- out_ready  in  1  downstream accepts box
- out_x, out_y  out  DATA_W each  sigmoid(x), sigmoid(y)
- out_w, out_h  out  DATA_W each  raw w, h
- out_obj  out  DATA_W  sigmoid(obj)
- out_box_idx  out  $clog2(B) (min 1)  box index within cell
- cell_done  out  1  one-cycle pulse after the last box of a cell is resolved
- boxes_kept  out  $clog2(B+1)  boxes emitted for the cell; valid while cell_done is high

Behaviour:
- Reset: in_ready=0 during reset and =1 on the first cycle after release. All other outputs and counters are 0. State is COLLECT. Reset mid-box or mid-emit discards the partial box without emitting it.
- Sigmoid, combinational on the accepted word, registered into the box register:
  - a = |x|, saturated: the most-negative input maps to the max positive value.
  - a >= 5.0 -> 1.0
  - 2.375 <= a < 5.0 -> (a>>5) + 0.84375
  - 1.0 <= a < 2.375 -> (a>>3) + 0.625
  - a < 1.0 -> (a>>2) + 0.5
  - For x < 0 the result is 1.0 - y.
  - Segment selection uses >=. All arithmetic is DATA_W wide and the result is never above 1.0.
- word_cnt counts 0..4+C and wraps to 0 after each box. box_cnt counts 0..B-1 and wraps to 0 after each cell.
- FSM:
  - COLLECT: in_ready=1. Each in_valid&&in_ready handshake stores the decoded field and advances word_cnt.
  - On the last word of a box (word_cnt==4+C, using the current obj when C=0): keep = sigmoid(obj) >= obj_thresh.
    - keep=1 -> go to EMIT.
    - keep=0 -> stay in COLLECT with no bubble; the next box's word is accepted the following cycle.
  - EMIT: in_ready=0, out_valid=1. Output fields stay stable until out_ready. On handshake, return to COLLECT and raise in_ready the next cycle. Latency from last-word acceptance to out_valid is 1 cycle.
- cell_done: asserts the cycle after the last box of a cell resolves. Resolving means either a suppressed last word, or the EMIT handshake of the last box. boxes_kept is the count for that cell and is held until the next cell_done; its counter clears for the next cell.
- Class words are accepted and discarded, except when the optional feature below is compiled in.
- The input is never back-pressured in COLLECT. out_ready without out_valid has no effect.

Optional Feature:
- Macro: YOLO_DETECT_CLASS_ARGMAX_EN.
- With the macro:
  - Adds ports out_class (out, $clog2(C) min 1) and out_class_score (out, DATA_W).
  - Tracks the running signed maximum of the class words; on ties the lowest index wins.
  - out_class_score = sigmoid(max).
  - Both fields are registered with the box and reset to 0.
  - With C=0 both fields are 0.
- Without the macro: no extra ports and no comparator logic.

Test Plan:
- Defaults, thresh=128. Box with x=0, y=0x0100, w=0x0123, h=0x0045, obj=0x0500, classes all 0 -> out_x=128, out_y=192, out_w=0x0123, out_h=0x0045, out_obj=256, out_box_idx=0. One cycle of latency.
- Sigmoid sweep of x over -0x0100, 0x0260, 0x8000, 0x7FFF -> 64, 235, 0, 256.
- One cell where box1 has obj=-0x0500 (sigmoid 0) and thresh=128 -> only boxes 0 and 2 emitted, no input bubble at the box1/box2 boundary, cell_done pulse with boxes_kept=2.
- out_ready held low for 10 cycles in EMIT -> in_ready=0, outputs stable. Release -> a single handshake, then in_ready=1 on the next cycle.
- rst asserted after word 3 of a box -> all outputs 0. The next full box decodes correctly with out_box_idx=0.
- With YOLO_DETECT_CLASS_ARGMAX_EN, class words 5,9,9,-3,... -> out_class=1, out_class_score=sigmoid(9)=130.
